rat_io_fifo_port: RTL

Port-mapped output peripheral that sits on the RAT MCU I/O bus (PORT_ID, OUT_PORT, IO_STRB, IN_PORT, INTR).
- CPU OUTPUT instructions to the data port push bytes into a FIFO.
- A downstream consumer (UART TX, display driver) drains the FIFO over a valid/ready handshake.
- Status and control are readable through IN_PORT.
- INTR raises a drain-complete interrupt to the MCU.

---
 rtl/rat_io_fifo_port.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rat_io_fifo_port.sv
// RAT MCU port-mapped output FIFO: OUTPUT writes to DATA_ID are queued and
// drained over a valid/ready handshake. Optional THRESH register: RAT_IO_FIFO_THRESH_EN.
module rat_io_fifo_port #(
  parameter int          DEPTH   = 16,
  parameter logic [7:0]  DATA_ID = 8'h40,
  parameter logic [7:0]  STAT_ID = 8'h41,
  parameter logic [7:0]  CTRL_ID = 8'h42
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INTR,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          ovf;
  logic          pend;
  logic          ie;

  logic data_wr;
  logic ctrl_wr;
  logic fifo_full;
  logic fifo_empty;
  logic pop_req;
  logic flush;
  logic pop_do;
  logic push_ok;
  logic push_drop;
  logic clr_ovf;
  logic ack;
  logic pend_hit;
  logic pend_set;

  assign data_wr    = IO_STRB && (PORT_ID == DATA_ID);
  assign ctrl_wr    = IO_STRB && (PORT_ID == CTRL_ID);
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == 5'd0);

  assign TX_VALID = !fifo_empty;
  assign TX_DATA  = mem[rd_ptr];

  assign flush   = ctrl_wr && OUT_PORT[2];
  assign clr_ovf = ctrl_wr && OUT_PORT[1];
  assign ack     = ctrl_wr && OUT_PORT[3];

  // A flush discards the head, so it overrides any handshake in the same cycle.
  assign pop_req   = TX_VALID && TX_READY;
  assign pop_do    = pop_req && !flush;
  assign push_ok   = data_wr && (!fifo_full || pop_do);
  assign push_drop = data_wr && fifo_full && !pop_do;

`ifdef RAT_IO_FIFO_THRESH_EN
  localparam logic [7:0] THRESH_ID = CTRL_ID + 8'd1;

  logic [4:0] thresh;
  logic [5:0] thresh_plus;
  logic       thresh_wr;

  assign thresh_wr   = IO_STRB && (PORT_ID == THRESH_ID);
  assign thresh_plus = {1'b0, thresh} + 6'd1;
  assign pend_hit    = (thresh < DEPTH_C) && ({1'b0, count} == thresh_plus);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      thresh <= 5'd0;
    end else if (thresh_wr) begin
      thresh <= OUT_PORT[4:0];
    end
  end
`else
  assign pend_hit = (count == 5'd1);
`endif

  // Only a real decrement of count crosses the threshold; push+pop holds count.
  assign pend_set = pop_do && !push_ok && pend_hit;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= OUT_PORT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_do) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_do})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf  <= 1'b0;
      pend <= 1'b0;
      ie   <= 1'b0;
      INTR <= 1'b0;
    end else begin
      if (push_drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end

      if (pend_set) begin
        pend <= 1'b1;
      end else if (ack) begin
        pend <= 1'b0;
      end

      if (ctrl_wr) begin
        ie <= OUT_PORT[0];
      end

      INTR <= ie && pend;
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    if (PORT_ID == STAT_ID) begin
      IN_PORT = {ovf, fifo_empty, fifo_full, count};
    end else if (PORT_ID == CTRL_ID) begin
      IN_PORT = {4'b0000, pend, 2'b00, ie};
    end
`ifdef RAT_IO_FIFO_THRESH_EN
    else if (PORT_ID == THRESH_ID) begin
      IN_PORT = {3'b000, thresh};
    end
`endif
  end

endmodule
